or_splitter: RTL and testbench
==============================

Name: or_splitter

Overview:
- Inverse of the bitwise OR merge primitive. Accepts one merged DATA_WIDTH-bit flag word and emits its set bits one at a time, lowest index first, as one-hot words with their bit index.
- The OR of all one-hot words emitted for an input word equals that input word.
- Sits in the primitives library. Fans merged interrupt/request words back out to per-source consumers over a valid/ready stream.

Parameters:
- DATA_WIDTH, 8, width of the input word and of each one-hot output word (must be ≥2).
- IDX_W, $clog2(DATA_WIDTH), width of out_index; derived localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_data  input  DATA_WIDTH  merged flag word.
- in_valid  input  1  in_data valid.
- in_ready  output  1  splitter can accept a word this cycle.
- out_onehot  output  DATA_WIDTH  current extracted bit, exactly one bit set when out_valid.
- out_index  output  IDX_W  bit position of out_onehot.
- out_last  output  1  current output is the final set bit of the word.
- out_valid  output  1  output fields valid.
- out_ready  input  1  consumer accepts the output this cycle.
- zero_word  output  1  one-cycle pulse: an all-zero word was accepted and dropped.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high. Every register is updated only on the rising edge of clk.
- Reset values: state=IDLE, remaining=0, out_valid=0, out_onehot=0, out_index=0, out_last=0, zero_word=0. in_ready=0 while reset is high.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - EMIT: out_valid=1.
- Input acceptance: a word is accepted when in_valid & in_ready at the clock edge.
  - in_data==0: stay in IDLE, zero_word=1 for the next cycle only, no output beat.
  - in_data!=0: remaining<=in_data, go to EMIT.
- Latency: the first out_valid is the cycle after acceptance. A word with k set bits needs k output handshakes.
- Outputs in EMIT are purely combinational from the registered remaining value:
  - out_onehot = remaining & (~remaining + 1).
  - out_index = position of that bit.
  - out_last = (remaining & (remaining-1))==0.
- Output handshake at out_valid & out_ready: remaining <= remaining & ~out_onehot.
  - If out_last is set, the next state is IDLE, unless a new word is accepted in the same cycle.
- Back-to-back words: in_ready = (state==IDLE) | (out_valid & out_ready & out_last). This is a combinational path from out_ready to in_ready and is documented as such.
  - A word accepted in the last-handshake cycle loads remaining directly, and EMIT continues with no bubble.
  - If that word is zero, raise zero_word and go to IDLE.
- Backpressure: while out_valid & ~out_ready, out_onehot, out_index and out_last hold stable. remaining is unchanged.
- Reset mid-operation: reset overrides any handshake. The partial word is discarded with no further beats, and the state returns to IDLE.
- Invariant: out_valid implies exactly one bit set in out_onehot and remaining != 0.
  - The verifier asserts this, plus stable-under-stall and OR-reconstruction of each word.

Decomposition:
- Package or_pkg holds:
  - the DATA_WIDTH default constant;
  - typedef enum logic {IDLE, EMIT} split_state_t;
  - function lsb_index(vector) returning IDX_W bits.
- One natural combinational sub-module, lsb_finder:
  - input: vector;
  - outputs: onehot, index, single (exactly one bit set);
  - instantiated once on remaining.

Test Plan:
- Reset: hold reset 2 cycles with in_valid=1, in_data=8'hFF -> in_ready=0, out_valid=0 throughout. First cycle after release: in_ready=1, no beat emitted.
- Basic split: accept 8'hA4, out_ready=1 -> beats on the next 3 cycles:
  - 8'h04 idx2 last=0;
  - 8'h20 idx5 last=0;
  - 8'h80 idx7 last=1.
  - OR of the beats = 8'hA4.
- Backpressure: accept 8'h81, out_ready=0 for 3 cycles -> 8'h01 idx0 held stable. Then out_ready=1 -> 8'h01 accepted, next beat 8'h80 idx7 last=1.
- Zero word: accept 8'h00 -> zero_word=1 for exactly one cycle after acceptance, out_valid stays 0, in_ready stays 1.
- Back-to-back: in_valid held with 8'h01 then 8'h02, out_ready=1 -> second word accepted in the same cycle as the 8'h01 last handshake. Beats 8'h01 idx0 last and 8'h02 idx1 last on consecutive cycles.
- Reset mid-word: accept 8'hF0, take 2 beats (8'h10, 8'h20), then assert reset -> next cycle out_valid=0. After release, accept 8'h08 -> single beat 8'h08 idx3 last=1, with no leftover 8'h40/8'h80 beats.

Source files
------------

// File: rtl/or_pkg.sv
// rtl/or_pkg.sv - shared types and helpers for the OR splitter
package or_pkg;

   localparam int DEFAULT_DATA_WIDTH = 8;
   localparam int DEFAULT_IDX_W      = $clog2(DEFAULT_DATA_WIDTH);

   typedef enum logic {IDLE, EMIT} split_state_t;

   // Position of the lowest set bit; returns 0 for an all-zero vector.
   function automatic logic [DEFAULT_IDX_W-1:0] lsb_index(input logic [DEFAULT_DATA_WIDTH-1:0] vector);
      logic [DEFAULT_IDX_W-1:0] idx;
      idx = '0;
      for (int i = DEFAULT_DATA_WIDTH - 1; i >= 0; i--) begin
         if (vector[i]) idx = DEFAULT_IDX_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/or_splitter_lsb_finder.sv
// rtl/or_splitter_lsb_finder.sv - isolates the lowest set bit of a vector
module lsb_finder #(
   parameter int WIDTH = 8,
   parameter int IDX_W = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] vector,
   output logic [WIDTH-1:0] onehot,
   output logic [IDX_W-1:0] index,
   output logic             single
);

   assign onehot = vector & (~vector + WIDTH'(1));
   assign single = (vector != '0) && ((vector & (vector - WIDTH'(1))) == '0);

   always_comb begin
      index = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (onehot[i]) index = IDX_W'(i);
      end
   end

endmodule

// File: rtl/or_splitter.sv
// rtl/or_splitter.sv - splits a merged flag word into one-hot beats, LSB first
module or_splitter
   import or_pkg::*;
#(
   parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   localparam int IDX_W      = $clog2(DATA_WIDTH)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] out_onehot,
   output logic [IDX_W-1:0]      out_index,
   output logic                  out_last,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  zero_word
);

   split_state_t          state;
   logic [DATA_WIDTH-1:0] remaining;
   logic                  single;
   logic                  accept;
   logic                  out_fire;

   lsb_finder #(
      .WIDTH (DATA_WIDTH),
      .IDX_W (IDX_W)
   ) u_lsb (
      .vector (remaining),
      .onehot (out_onehot),
      .index  (out_index),
      .single (single)
   );

   assign out_valid = (state == EMIT);
   assign out_last  = out_valid & single;
   assign out_fire  = out_valid & out_ready;

   // out_ready reaches in_ready combinationally so a new word can load on the final beat.
   assign in_ready  = ~reset & ((state == IDLE) | (out_fire & out_last));
   assign accept    = in_valid & in_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         remaining <= '0;
         zero_word <= 1'b0;
      end else begin
         zero_word <= 1'b0;
         if (accept) begin
            if (in_data == '0) begin
               zero_word <= 1'b1;
               remaining <= '0;
               state     <= IDLE;
            end else begin
               remaining <= in_data;
               state     <= EMIT;
            end
         end else if (out_fire) begin
            remaining <= remaining & ~out_onehot;
            if (out_last) state <= IDLE;
         end
      end
   end

endmodule

// File: tb/tb_or_splitter.sv
// tb/tb_or_splitter.sv - directed self-checking bench for or_splitter
module tb_or_splitter;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] out_onehot;
   logic [2:0] out_index;
   logic       out_last;
   logic       out_valid;
   logic       out_ready;
   logic       zero_word;

   int n_cmp = 0;
   int n_bad = 0;
   logic [7:0] acc;

   always #5 clk = ~clk;

   or_splitter #(.DATA_WIDTH(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out_onehot (out_onehot),
      .out_index  (out_index),
      .out_last   (out_last),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .zero_word  (zero_word)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input string tag, input logic [7:0] oh, input logic [2:0] idx, input logic last);
      check_eq({tag, ".valid"}, 32'(out_valid), 32'd1);
      check_eq({tag, ".onehot"}, 32'(out_onehot), 32'(oh));
      check_eq({tag, ".index"}, 32'(out_index), 32'(idx));
      check_eq({tag, ".last"}, 32'(out_last), 32'(last));
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b1; in_data = 8'hFF; out_ready = 1'b1;

      // reset held two cycles with an input offered
      step();
      check_eq("rst1.in_ready", 32'(in_ready), 32'd0);
      check_eq("rst1.out_valid", 32'(out_valid), 32'd0);
      step();
      check_eq("rst2.in_ready", 32'(in_ready), 32'd0);
      check_eq("rst2.out_valid", 32'(out_valid), 32'd0);
      check_eq("rst2.onehot", 32'(out_onehot), 32'd0);
      check_eq("rst2.index", 32'(out_index), 32'd0);
      check_eq("rst2.last", 32'(out_last), 32'd0);
      check_eq("rst2.zero_word", 32'(zero_word), 32'd0);
      reset = 1'b0; in_valid = 1'b0;
      #1;
      check_eq("rel.in_ready", 32'(in_ready), 32'd1);
      step();
      check_eq("rel.out_valid", 32'(out_valid), 32'd0);

      // basic split of 0xA4
      in_data = 8'hA4; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      acc = 8'h00;
      beat("a4.b0", 8'h04, 3'd2, 1'b0); acc |= out_onehot;
      check_eq("a4.in_ready_busy", 32'(in_ready), 32'd0);
      step();
      beat("a4.b1", 8'h20, 3'd5, 1'b0); acc |= out_onehot;
      step();
      beat("a4.b2", 8'h80, 3'd7, 1'b1); acc |= out_onehot;
      step();
      check_eq("a4.done", 32'(out_valid), 32'd0);
      check_eq("a4.or", 32'(acc), 32'hA4);

      // backpressure on 0x81
      out_ready = 1'b0;
      in_data = 8'h81; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         beat($sformatf("81.stall%0d", i), 8'h01, 3'd0, 1'b0);
         step();
      end
      out_ready = 1'b1;
      beat("81.b0", 8'h01, 3'd0, 1'b0);
      step();
      beat("81.b1", 8'h80, 3'd7, 1'b1);
      step();
      check_eq("81.done", 32'(out_valid), 32'd0);

      // zero word dropped with a one-cycle pulse
      in_data = 8'h00; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      check_eq("zero.pulse", 32'(zero_word), 32'd1);
      check_eq("zero.out_valid", 32'(out_valid), 32'd0);
      check_eq("zero.in_ready", 32'(in_ready), 32'd1);
      step();
      check_eq("zero.pulse_end", 32'(zero_word), 32'd0);
      check_eq("zero.out_valid2", 32'(out_valid), 32'd0);

      // back-to-back single-bit words
      in_data = 8'h01; in_valid = 1'b1;
      step();
      in_data = 8'h02;
      beat("b2b.w0", 8'h01, 3'd0, 1'b1);
      check_eq("b2b.in_ready_last", 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
      beat("b2b.w1", 8'h02, 3'd1, 1'b1);
      step();
      check_eq("b2b.done", 32'(out_valid), 32'd0);

      // reset in the middle of 0xF0
      in_data = 8'hF0; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      beat("f0.b0", 8'h10, 3'd4, 1'b0);
      step();
      beat("f0.b1", 8'h20, 3'd5, 1'b0);
      step();
      reset = 1'b1;
      #1;
      check_eq("f0.rst_in_ready", 32'(in_ready), 32'd0);
      step();
      check_eq("f0.rst_out_valid", 32'(out_valid), 32'd0);
      reset = 1'b0;
      in_data = 8'h08; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      beat("08.b0", 8'h08, 3'd3, 1'b1);
      step();
      check_eq("08.done", 32'(out_valid), 32'd0);
      step();
      check_eq("08.no_leftover", 32'(out_valid), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
